rsc_encoder_par: RTL
====================

Name: rsc_encoder_par

Overview:
Parametrised parallel recursive systematic convolutional (RSC) constituent encoder for the turbo encoder, LTE 36.212 generators g0 = 1+D^2+D^3 (feedback) and g1 = 1+D+D^3 (parity). It consumes P input bits per cycle with a valid/stall handshake and a runtime block length. It terminates the trellis and emits the 3 tail x/z pairs. It is instantiated twice (natural order and interleaved order) under the turbo encoder top.

Parameters:
P, 8, bits per beat; legal values are 1, 2, 4, 8.
KW, 13, width of k_len.
KMAX, 6144, largest legal block length in bits.

Ports:
clk  in  1  clock
aclr  in  1  reset
start  in  1  one-cycle pulse that begins a block
k_len  in  KW  block length in bits, sampled on accepted start
in_valid  in  1  ck carries a valid beat
ck  in  P  input bits, ck[0] earliest in time
busy  out  1  block in progress (DATA or TAIL)
out_valid  out  1  xk/zk valid
xk  out  P  systematic bits (copy of accepted ck)
zk  out  P  parity bits, zk[0] earliest
last  out  1  marks the final data beat (with out_valid)
tail_valid  out  1  one-cycle pulse, tail_x/tail_z valid
tail_x  out  3  tail systematic bits, bit0 = x_K
tail_z  out  3  tail parity bits, bit0 = z_K
err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Clocking and reset: single clock domain clk. aclr is synchronous and active-high. On aclr: state <- IDLE; s[2:0] <- 0; beat counter <- 0. All outputs <- 0 (busy, out_valid, xk, zk, last, tail_valid, tail_x, tail_z, err). aclr asserted mid-block aborts the block immediately and emits no partial tail.
- Encoder state: s0, s1, s2 (D1..D3).
- Per bit c, in order ck[0]..ck[P-1]:
  - w = c^s1^s2
  - z = w^s0^s2
  - then s2<=s1, s1<=s0, s0<=w
- Hardware unrolls P steps combinationally in one cycle.
- FSM states: IDLE, DATA, TAIL.
- IDLE:
  - start=1 with legal k_len (k_len>=P, k_len<=KMAX, k_len%P==0): latch beats = k_len/P, clear s, go to DATA.
  - Illegal k_len: err=1 for 1 cycle; stay in IDLE.
  - in_valid is ignored in IDLE.
- DATA:
  - Each cycle with in_valid=1 is one accepted beat. Next cycle: out_valid=1, xk=ck, zk=parity. Latency is exactly 1 cycle.
  - in_valid=0 stalls. State and counter hold, and out_valid=0 next cycle.
  - The accepted beat number `beats` sets last=1 on its output cycle; the FSM then moves to TAIL.
- TAIL: one cycle.
  - Termination input per step: x=s1^s2 (forces w=0); z=s0^s2; then shift with w=0. Unroll 3 steps.
  - Next cycle: tail_valid=1 with tail_x/tail_z. The FSM returns to IDLE and s is 0.
  - in_valid in TAIL is ignored.
- busy=1 in DATA and TAIL. start while busy is ignored (no err).
- Back-to-back blocks: start is accepted in the same cycle tail_valid is asserted (FSM already in IDLE). Minimum gap between blocks is 0 idle cycles beyond TAIL.
- Outputs are registered. With P=1, every output is bit-exact with the serial 36.212 encoder.

Decomposition:
- Package turbo_pkg holds:
  - FSM state enum (IDLE/DATA/TAIL)
  - KMAX, the generator constants
  - function rsc_step(state, c) returning {next_state, z}, reused for data and tail unrolling
- Sub-module: rsc_unroll (combinational, parameter N). Takes s_in and N input bits; returns s_out and N parity bits. It is instantiated for the P-bit data path and for the 3-step tail (tail inputs generated internally).

Test Plan:
- All-zero block, P=8, k_len=40 -> 5 beats with zk=0x00, last on beat 5, tail_x=0, tail_z=0, busy drops after tail_valid.
- Impulse, P=8, k_len=8, ck=0x01 -> zk=0x4F, last=1. Next cycle: tail_valid=1, tail_x=3'b110, tail_z=3'b101.
- Stall: k_len=16, P=8, in_valid pattern 1,0,0,1 with ck=0x01,0x00 -> zk beats 0x4F then the continuation. out_valid is low during the stall gaps, and the result is identical to the unstalled run.
- Cross-P equivalence: the same random 6144-bit block on P=1,2,4,8 -> identical serialised zk and identical tail_x/tail_z.
- Illegal starts: k_len=0, 12 (P=8), and 6152 -> err pulse each time, busy stays 0, outputs unchanged. A start during DATA is ignored.
- Reset mid-block: aclr on beat 3 of 5 -> all outputs 0 next cycle and no tail_valid. A new block started afterward encodes from zero state (matches the impulse test).

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo constituent encoders: FSM states,
// block-size limit, generator polynomials and the single-bit trellis step.
package turbo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } rsc_state_e;

  localparam int TURBO_KMAX = 6144;

  // Generator coefficients, bit i = coefficient of D^i.
  // G0 = 1 + D^2 + D^3 (feedback), G1 = 1 + D + D^3 (parity).
  localparam logic [3:0] G0 = 4'b1101;
  localparam logic [3:0] G1 = 4'b1011;

  // One trellis step. s[0]=s0 (D1), s[1]=s1 (D2), s[2]=s2 (D3).
  // Returns {next_state[2:0], z}.
  function automatic logic [3:0] rsc_step(input logic [2:0] s, input logic c);
    logic w;
    logic z;
    w = c ^ (G0[1] & s[0]) ^ (G0[2] & s[1]) ^ (G0[3] & s[2]);
    z = (G1[0] & w) ^ (G1[1] & s[0]) ^ (G1[2] & s[1]) ^ (G1[3] & s[2]);
    return {s[1], s[0], w, z};
  endfunction

endpackage

// File: rtl/rsc_unroll.sv
// Combinational N-step unrolling of the RSC trellis.
// TERM=0: c_in drives the encoder (data path).
// TERM=1: each step's input is the feedback-cancelling bit s1^s2 so the
// register drains to zero; c_in is XORed on top and should be tied to 0.
module rsc_unroll
  import turbo_pkg::*;
#(
  parameter int N    = 8,
  parameter bit TERM = 1'b0
) (
  input  logic [2:0]   s_in,
  input  logic [N-1:0] c_in,
  output logic [2:0]   s_out,
  output logic [N-1:0] x_out,
  output logic [N-1:0] z_out
);

  // Walk the trellis N steps, c_in[0] first.
  always_comb begin
    logic [2:0] s;
    logic       c;
    logic [3:0] r;
    s     = s_in;
    c     = 1'b0;
    r     = '0;
    x_out = '0;
    z_out = '0;
    for (int i = 0; i < N; i++) begin
      c        = c_in[i] ^ (TERM ? (s[1] ^ s[2]) : 1'b0);
      r        = rsc_step(s, c);
      x_out[i] = c;
      z_out[i] = r[0];
      s        = r[3:1];
    end
    s_out = s;
  end

endmodule

// File: rtl/rsc_encoder_par.sv
// Parallel RSC constituent encoder: P bits per beat, runtime block length,
// trellis termination with 3 tail x/z pairs. All outputs are registered.
// Handshake: a beat is accepted on any DATA-state cycle with in_valid=1;
// its xk/zk appear with out_valid exactly one cycle later. There is no
// back-pressure on the output side.
module rsc_encoder_par
  import turbo_pkg::*;
#(
  parameter int P    = 8,           // 1, 2, 4 or 8
  parameter int KW   = 13,
  parameter int KMAX = TURBO_KMAX
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          in_valid,
  input  logic [P-1:0]  ck,
  output logic          busy,
  output logic          out_valid,
  output logic [P-1:0]  xk,
  output logic [P-1:0]  zk,
  output logic          last,
  output logic          tail_valid,
  output logic [2:0]    tail_x,
  output logic [2:0]    tail_z,
  output logic          err
);

  localparam int LOG_P = $clog2(P);

  rsc_state_e    state, state_nxt;
  logic [2:0]    s;
  logic [KW-1:0] beats, beat_cnt;

  logic          k_ok, start_ok, start_bad, accept, final_beat;
  logic [2:0]    d_s, t_s, t_x, t_z;
  logic [P-1:0]  d_x, d_z;

  logic          busy_n, out_valid_n, last_n, tail_valid_n, err_n;
  logic [P-1:0]  xk_n, zk_n;
  logic [2:0]    tail_x_n, tail_z_n;

  rsc_unroll #(.N(P), .TERM(1'b0)) u_data (
    .s_in  (s),
    .c_in  (ck),
    .s_out (d_s),
    .x_out (d_x),
    .z_out (d_z)
  );

  rsc_unroll #(.N(3), .TERM(1'b1)) u_tail (
    .s_in  (s),
    .c_in  (3'b000),
    .s_out (t_s),
    .x_out (t_x),
    .z_out (t_z)
  );

  // Start qualification and beat acceptance.
  always_comb begin
    k_ok       = (k_len >= KW'(P)) && (k_len <= KW'(KMAX)) &&
                 ((k_len & KW'(P - 1)) == '0);
    start_ok   = (state == ST_IDLE) && start && k_ok;
    start_bad  = (state == ST_IDLE) && start && !k_ok;
    accept     = (state == ST_DATA) && in_valid;
    final_beat = accept && (beat_cnt == beats - KW'(1));
  end

  // State register, trellis state and beat counter.
  always_ff @(posedge clk) begin
    if (aclr) begin
      state    <= ST_IDLE;
      s        <= '0;
      beat_cnt <= '0;
      beats    <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        s        <= '0;
        beat_cnt <= '0;
        beats    <= k_len >> LOG_P;
      end else if (accept) begin
        s        <= d_s;
        beat_cnt <= beat_cnt + KW'(1);
      end else if (state == ST_TAIL) begin
        // Termination drains the register; t_s is zero by construction.
        s <= t_s;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_ok)   state_nxt = ST_DATA;
      ST_DATA: if (final_beat) state_nxt = ST_TAIL;
      ST_TAIL:                 state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Output next-values; xk/zk and tail words hold between updates.
  always_comb begin
    busy_n       = (state_nxt != ST_IDLE);
    out_valid_n  = accept;
    xk_n         = accept ? d_x : xk;
    zk_n         = accept ? d_z : zk;
    last_n       = final_beat;
    tail_valid_n = (state == ST_TAIL);
    tail_x_n     = (state == ST_TAIL) ? t_x : tail_x;
    tail_z_n     = (state == ST_TAIL) ? t_z : tail_z;
    err_n        = start_bad;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (aclr) begin
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      xk         <= '0;
      zk         <= '0;
      last       <= 1'b0;
      tail_valid <= 1'b0;
      tail_x     <= '0;
      tail_z     <= '0;
      err        <= 1'b0;
    end else begin
      busy       <= busy_n;
      out_valid  <= out_valid_n;
      xk         <= xk_n;
      zk         <= zk_n;
      last       <= last_n;
      tail_valid <= tail_valid_n;
      tail_x     <= tail_x_n;
      tail_z     <= tail_z_n;
      err        <= err_n;
    end
  end

endmodule
